// File: rtl/shiftreg_pkg.sv
// Shared mode codes, FSM encoding and helpers for the shift-register scheduler.
// Mode codes match the select inputs of the shared universal shift register.
package shiftreg_pkg;

   localparam logic [1:0] SR_HOLD  = 2'b00;
   localparam logic [1:0] SR_RIGHT = 2'b01;
   localparam logic [1:0] SR_LEFT  = 2'b10;
   localparam logic [1:0] SR_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [1:0] shift_mode(input logic dir);
      return dir ? SR_LEFT : SR_RIGHT;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, combinational from valid.
// Pointer moves only on advance, away from the requester just served.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   // prefer_q = index of the requester that wins a tie
   logic prefer_q, prefer_d;

   always_comb begin
      grant_o = 2'b00;
      unique case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = prefer_q ? 2'b10 : 2'b01;
         default: grant_o = 2'b00;
      endcase
   end

   always_comb begin
      prefer_d = prefer_q;
      if (advance_i && (grant_o != 2'b00))
         prefer_d = grant_o[0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prefer_q <= 1'b0;
      else
         prefer_q <= prefer_d;
   end

endmodule

// File: rtl/shiftreg_sched.sv
// Schedules two requesters onto one universal shift register: load, COUNT shifts, done pulse.
// Latency accept->done = COUNT+2 cycles; requests wait on ready while a job is in flight.
module shiftreg_sched
   import shiftreg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNTW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_dir,
   input  logic [CNTW-1:0]  req0_count,
   output logic             req0_done,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_dir,
   input  logic [CNTW-1:0]  req1_count,
   output logic             req1_done,
   output logic [WIDTH-1:0] req_result,
   output logic             busy,
   output logic [WIDTH-1:0] sr_a,
   output logic [1:0]       sr_s,
   input  logic [WIDTH-1:0] sr_q
);

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             dir_q;
   logic             owner_q;
   logic [WIDTH-1:0] sr_a_q;
   logic [WIDTH-1:0] result_q;
   logic [1:0]       grant;
   logic             accept;

   rr_arb2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .valid_i   ({req1_valid, req0_valid}),
      .advance_i (accept),
      .grant_o   (grant)
   );

   // Readies are gated by reset so nothing looks accepted while reset is held.
   assign req0_ready = reset && (state_q == ST_IDLE) && grant[0] && req0_valid;
   assign req1_ready = reset && (state_q == ST_IDLE) && grant[1] && req1_valid;
   assign accept     = req0_ready || req1_ready;

   assign sr_a       = sr_a_q;
   assign req_result = (state_q == ST_DONE) ? sr_q : result_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_s      = SR_HOLD;
      busy      = 1'b1;
      req0_done = 1'b0;
      req1_done = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (accept)
               state_d = ST_LOAD;
         end
         ST_LOAD: begin
            sr_s    = SR_LOAD;
            state_d = (cnt_q == '0) ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            sr_s  = shift_mode(dir_q);
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            req0_done = !owner_q;
            req1_done = owner_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         owner_q  <= 1'b0;
         sr_a_q   <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // Command fields are captured only on the accept edge.
         if (accept) begin
            owner_q <= req1_ready;
            sr_a_q  <= req1_ready ? req1_data  : req0_data;
            dir_q   <= req1_ready ? req1_dir   : req0_dir;
            cnt_q   <= req1_ready ? req1_count : req0_count;
         end
         if (state_q == ST_DONE)
            result_q <= sr_q;
      end
   end

endmodule

// File: tb/tb_shiftreg_sched.sv
// Bench for shiftreg_sched with a behavioural universal shift register attached.
module tb_shiftreg_sched;

   localparam int W = 4;
   localparam int C = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         v  [2];
   logic [W-1:0] d  [2];
   logic         dr [2];
   logic [C-1:0] c  [2];

   logic         rdy0, rdy1, dn0, dn1, busy;
   logic [W-1:0] res, sr_a, sr_q;
   logic [1:0]   sr_s;
   logic [1:0]   rdy_v, dn_v;
   assign rdy_v = {rdy1, rdy0};
   assign dn_v  = {dn1, dn0};

   int total = 0;
   int bad   = 0;

   shiftreg_sched #(.WIDTH(W), .CNTW(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (v[0]),
      .req0_ready (rdy0),
      .req0_data  (d[0]),
      .req0_dir   (dr[0]),
      .req0_count (c[0]),
      .req0_done  (dn0),
      .req1_valid (v[1]),
      .req1_ready (rdy1),
      .req1_data  (d[1]),
      .req1_dir   (dr[1]),
      .req1_count (c[1]),
      .req1_done  (dn1),
      .req_result (res),
      .busy       (busy),
      .sr_a       (sr_a),
      .sr_s       (sr_s),
      .sr_q       (sr_q)
   );

   // Team shift register: shifts in zero at either end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sr_q <= '0;
      else begin
         case (sr_s)
            2'b01:   sr_q <= sr_q >> 1;
            2'b10:   sr_q <= sr_q << 1;
            2'b11:   sr_q <= sr_a;
            default: sr_q <= sr_q;
         endcase
      end
   end

   function automatic logic [W-1:0] ref_result(input logic [W-1:0] dat, input logic dir, input int cnt);
      int unsigned x;
      x = dat;
      x = dir ? (x << cnt) : (x >> cnt);
      return x[W-1:0];
   endfunction

   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic run_job(input int n, input logic [W-1:0] dat, input logic dir, input int cnt);
      int w;
      logic [1:0] exp_s;
      logic [W-1:0] exp_r;
      exp_r = ref_result(dat, dir, cnt);
      v[n] = 1'b1; d[n] = dat; dr[n] = dir; c[n] = C'(cnt);
      w = 0;
      @(negedge clk);
      while (!rdy_v[n] && w < 20) begin @(negedge clk); w++; end
      total++;
      if (!rdy_v[n]) begin
         bad++; $display("FAIL job_ready req%0d: ready=%b required 1", n, rdy_v[n]);
         v[n] = 1'b0; @(posedge clk); #1; return;
      end
      @(posedge clk); #1;
      v[n] = 1'b0; d[n] = W'($urandom); c[n] = C'($urandom);
      for (int i = 1; i <= cnt + 2; i++) begin
         @(negedge clk);
         exp_s = (i == 1) ? 2'b11 : (i <= cnt + 1) ? (dir ? 2'b10 : 2'b01) : 2'b00;
         total++;
         if (sr_s !== exp_s) begin bad++; $display("FAIL sr_mode cyc%0d: sr_s=%b required %b", i, sr_s, exp_s); end
         if (i == 1) begin
            total++;
            if (sr_a !== dat) begin bad++; $display("FAIL sr_a_load: sr_a=%b required %b", sr_a, dat); end
         end
         total++;
         if (dn_v[n] !== (i == cnt + 2) || dn_v[1-n] !== 1'b0) begin
            bad++; $display("FAIL done_timing cyc%0d: done=%b required req%0d at cyc%0d", i, dn_v, n, cnt + 2);
         end
         total++;
         if (busy !== 1'b1) begin bad++; $display("FAIL busy cyc%0d: busy=%b required 1", i, busy); end
         if (i == cnt + 2) begin
            total++;
            if (res !== exp_r) begin bad++; $display("FAIL result: res=%b required %b", res, exp_r); end
         end
      end
      @(negedge clk);
      total++;
      if (res !== exp_r || busy !== 1'b0 || dn_v !== 2'b00) begin
         bad++; $display("FAIL result_hold: res=%b busy=%b done=%b required %b/0/00", res, busy, dn_v, exp_r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; v[0] = 1'b1; d[0] = 4'b1010; dr[0] = 1'b1; c[0] = 3'd2;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (sr_s !== 2'b00 || rdy0 !== 1'b0 || dn_v !== 2'b00 || busy !== 1'b0 || res !== '0 || sr_a !== '0) begin
            bad++; $display("FAIL reset_state: sr_s=%b rdy0=%b done=%b busy=%b res=%b sr_a=%b required all 0",
                            sr_s, rdy0, dn_v, busy, res, sr_a);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (rdy0 !== 1'b1) begin bad++; $display("FAIL ready_after_reset: rdy0=%b required 1", rdy0); end
      v[0] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_job(0, 4'b1101, 1'b1, 1);
      run_job(1, 4'b1101, 1'b0, 0);
      run_job(0, 4'b1101, 1'b0, 3);
      run_job(0, 4'b1101, 1'b0, 7);
      run_job(1, 4'b0011, 1'b1, 5);
   endtask

   task automatic test_rr_alternate();
      int acc;
      int who;
      pulse_reset();
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b1; d[n] = W'($urandom); dr[n] = 1'($urandom); c[n] = '0;
      end
      acc = 0;
      for (int k = 0; k < 80 && acc < 4; k++) begin
         @(negedge clk);
         total++;
         if (rdy0 && rdy1) begin bad++; $display("FAIL rr_both_ready: rdy=%b required one-hot or 0", rdy_v); end
         if (rdy_v != 2'b00) begin
            who = rdy1 ? 1 : 0;
            total++;
            if (who != acc % 2) begin bad++; $display("FAIL rr_order accept%0d: req%0d required req%0d", acc, who, acc % 2); end
            acc++;
         end
      end
      total++;
      if (acc != 4) begin bad++; $display("FAIL rr_count: accepts=%0d required 4", acc); end
      @(posedge clk); #1;
      v[0] = 1'b0; v[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int w;
      v[0] = 1'b1; d[0] = 4'b1011; dr[0] = 1'b0; c[0] = 3'd5;
      w = 0;
      @(negedge clk);
      while (!rdy0 && w < 20) begin @(negedge clk); w++; end
      total++;
      if (!rdy0) begin bad++; $display("FAIL midreset_ready: rdy0=%b required 1", rdy0); end
      @(posedge clk); #1;
      v[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if (sr_s !== 2'b00 || busy !== 1'b0 || dn_v !== 2'b00 || res !== '0 || sr_a !== '0) begin
         bad++; $display("FAIL midreset_outputs: sr_s=%b busy=%b done=%b res=%b sr_a=%b required all 0",
                         sr_s, busy, dn_v, res, sr_a);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (8) begin
         @(negedge clk);
         total++;
         if (dn_v !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_no_done: done=%b busy=%b required 00/0", dn_v, busy);
         end
      end
      @(posedge clk); #1;
      run_job(1, 4'b0110, 1'b1, 2);
   endtask

   task automatic test_random();
      logic pend, pend_start;
      int   exp_owner, exp_at, cyc, last, who, expg, accepted;
      logic [W-1:0] exp_res;
      pulse_reset();
      pend = 1'b0; last = 1; cyc = 0; exp_owner = 0; exp_at = 0; exp_res = '0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'($urandom); d[n] = W'($urandom); dr[n] = 1'($urandom); c[n] = C'($urandom);
      end
      for (int k = 0; k < 470; k++) begin
         if (k >= 400 && !pend) break;
         @(negedge clk);
         pend_start = pend;
         total++;
         if (pend && cyc == exp_at) begin
            if (dn_v[exp_owner] !== 1'b1 || dn_v[1-exp_owner] !== 1'b0 || res !== exp_res) begin
               bad++; $display("FAIL rand_done cyc%0d: done=%b res=%b required req%0d res=%b", cyc, dn_v, res, exp_owner, exp_res);
            end
            pend = 1'b0;
         end else if (dn_v !== 2'b00) begin
            bad++; $display("FAIL rand_spurious_done cyc%0d: done=%b required 00", cyc, dn_v);
         end
         total++;
         if ((rdy_v != 2'b00) !== (!pend_start && (v[0] || v[1])) || (rdy0 && rdy1)) begin
            bad++; $display("FAIL rand_ready cyc%0d: rdy=%b required one-hot when idle with request", cyc, rdy_v);
         end
         accepted = -1;
         if (rdy_v != 2'b00) begin
            who  = rdy1 ? 1 : 0;
            expg = (v[0] && v[1]) ? (last == 0 ? 1 : 0) : (v[1] ? 1 : 0);
            total++;
            if (who != expg) begin bad++; $display("FAIL rand_grant cyc%0d: req%0d required req%0d", cyc, who, expg); end
            pend = 1'b1; exp_owner = who; last = who; accepted = who;
            exp_res = ref_result(d[who], dr[who], int'(c[who]));
            exp_at  = cyc + int'(c[who]) + 2;
         end
         @(posedge clk); #1;
         cyc++;
         for (int n = 0; n < 2; n++) begin
            if (k >= 399) v[n] = 1'b0;
            else if (accepted == n || (!v[n] && $urandom_range(0, 2) == 0)) begin
               v[n] = (accepted == n) ? 1'($urandom) : 1'b1;
               d[n] = W'($urandom); dr[n] = 1'($urandom); c[n] = C'($urandom);
            end
         end
      end
      total++;
      if (pend) begin bad++; $display("FAIL rand_drain: job pending=%b required 0", pend); end
   endtask

   initial begin
      reset = 1'b0;
      for (int n = 0; n < 2; n++) begin v[n] = 1'b0; d[n] = '0; dr[n] = 1'b0; c[n] = '0; end
      #1;
      test_reset();
      test_directed();
      test_rr_alternate();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
